fetch_unit_rv: RTL

Instruction fetch stage for the RV core, directly upstream of the next-PC calculator. Holds the fetch PC, issues sequential word requests to instruction memory over a valid/ready handshake, and buffers up to two returned instructions for decode. On each consumed instruction it compares the resolved next PC against its sequential prediction and flushes on mismatch. It supplies the current instruction PC to next-PC logic and takes the resolved next PC back.

---
 rtl/fetch_unit_rv.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit_rv.sv
// fetch_unit_rv: instruction fetch stage for the RV core.
// Holds the fetch PC, issues sequential word requests to instruction memory
// over a valid/ready handshake, buffers up to two returned instructions for
// decode, and redirects when the resolved next PC differs from PC+4.
//
// Ports:
//   iwClock, iwReset_n        clock (rising edge), async active-low reset
//   owImemReqValid/owImemAddr fetch request toward instruction memory
//   iwImemReqReady            memory accepts the request this cycle
//   iwImemRespValid/Data      in-order instruction responses
//   owInstValid/owInstruction buffer head toward decode
//   owCurrentPc               PC of buffer head (to next-PC logic)
//   iwInstReady               decode consumes the head this cycle
//   iwNextPc                  resolved next PC of the head
//   owMisalignedPc            one-cycle pulse on a misaligned resolved PC
module fetch_unit_rv #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iwClock,
  input  logic        iwReset_n,
  output logic        owImemReqValid,
  output logic [31:0] owImemAddr,
  input  logic        iwImemReqReady,
  input  logic        iwImemRespValid,
  input  logic [31:0] iwImemRespData,
  output logic        owInstValid,
  output logic [31:0] owInstruction,
  output logic [31:0] owCurrentPc,
  input  logic        iwInstReady,
  input  logic [31:0] iwNextPc,
  output logic        owMisalignedPc
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;   // holds 0..DEPTH
  localparam int unsigned SW    = 3;   // credit sum width

  // Architectural state
  logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
  logic            req_valid_q,   req_valid_d;
  logic [XLEN-1:0] req_addr_q,    req_addr_d;
  logic            req_stale_q,   req_stale_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q,     discard_d;
  logic [XLEN-1:0] ob_addr_q [DEPTH];
  logic [XLEN-1:0] ob_addr_d [DEPTH];
  logic [CW-1:0]   count_q,       count_d;
  logic [XLEN-1:0] fifo_pc_q   [DEPTH];
  logic [XLEN-1:0] fifo_pc_d   [DEPTH];
  logic [XLEN-1:0] fifo_inst_q [DEPTH];
  logic [XLEN-1:0] fifo_inst_d [DEPTH];
  logic            inst_valid_q,  inst_valid_d;
  logic            mis_q,         mis_d;

  // Per-cycle events
  logic            accept;
  logic            resp;
  logic            consume;
  logic            redirect;
  logic            drop;
  logic            push;
  logic            pending_after;
  logic [XLEN-1:0] pred_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   ob_after_resp;
  logic [CW-1:0]   cnt_after_pop;

  // Next-state logic
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_valid_d   = req_valid_q;
    req_addr_d    = req_addr_q;
    req_stale_d   = req_stale_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    ob_addr_d     = ob_addr_q;
    count_d       = count_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_inst_d   = fifo_inst_q;
    inst_valid_d  = inst_valid_q;
    mis_d         = 1'b0;

    accept        = req_valid_q & iwImemReqReady;
    resp          = iwImemRespValid & (outstanding_q != '0);
    consume       = inst_valid_q & iwInstReady;
    pred_pc       = fifo_pc_q[0] + XLEN'(4);
    redirect      = consume & (iwNextPc != pred_pc);
    target_pc     = {iwNextPc[XLEN-1:2], 2'b00};
    drop          = resp & (discard_q != '0);
    push          = resp & ~drop & ~redirect;
    pending_after = req_valid_q & ~accept;

    // In-order address tracker for accepted requests; head = oldest
    if (resp) begin
      ob_addr_d[0] = ob_addr_q[1];
    end
    ob_after_resp = outstanding_q - CW'(resp);
    if (accept) begin
      if (ob_after_resp == '0) begin
        ob_addr_d[0] = req_addr_q;
      end else begin
        ob_addr_d[1] = req_addr_q;
      end
    end
    outstanding_d = ob_after_resp + CW'(accept);

    // Discard budget; a pending request that is not yet accepted is counted too,
    // since it will come back carrying a pre-redirect address
    discard_d = discard_q - CW'(drop);
    if (redirect) begin
      discard_d = outstanding_d + CW'(pending_after);
    end

    // Two-entry buffer: pop shifts entry 1 to head, push lands behind survivors
    cnt_after_pop = count_q - CW'(consume);
    if (consume) begin
      fifo_pc_d[0]   = fifo_pc_q[1];
      fifo_inst_d[0] = fifo_inst_q[1];
    end
    if (push) begin
      if (cnt_after_pop == '0) begin
        fifo_pc_d[0]   = ob_addr_q[0];
        fifo_inst_d[0] = iwImemRespData;
      end else begin
        fifo_pc_d[1]   = ob_addr_q[0];
        fifo_inst_d[1] = iwImemRespData;
      end
    end
    count_d = cnt_after_pop + CW'(push);
    if (redirect) begin
      count_d = '0;
    end
    inst_valid_d = (count_d != '0);

    // Fetch PC only advances for requests on the current path
    if (accept && !req_stale_q) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (redirect) begin
      fetch_pc_d = target_pc;
    end

    // Request: hold an unaccepted request; otherwise issue when credit allows
    if (pending_after) begin
      req_valid_d = 1'b1;
      req_addr_d  = req_addr_q;
      req_stale_d = req_stale_q | redirect;
    end else begin
      req_valid_d = ((SW'(count_d) + SW'(outstanding_d)) < SW'(DEPTH));
      req_addr_d  = fetch_pc_d;
      req_stale_d = 1'b0;
    end

    mis_d = consume & (iwNextPc[1:0] != 2'b00);
  end

  // State registers
  always_ff @(posedge iwClock or negedge iwReset_n) begin
    if (!iwReset_n) begin
      fetch_pc_q     <= RESET_PC;
      req_valid_q    <= 1'b0;
      req_addr_q     <= RESET_PC;
      req_stale_q    <= 1'b0;
      outstanding_q  <= '0;
      discard_q      <= '0;
      ob_addr_q[0]   <= '0;
      ob_addr_q[1]   <= '0;
      count_q        <= '0;
      fifo_pc_q[0]   <= RESET_PC;
      fifo_pc_q[1]   <= '0;
      fifo_inst_q[0] <= '0;
      fifo_inst_q[1] <= '0;
      inst_valid_q   <= 1'b0;
      mis_q          <= 1'b0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      req_valid_q    <= req_valid_d;
      req_addr_q     <= req_addr_d;
      req_stale_q    <= req_stale_d;
      outstanding_q  <= outstanding_d;
      discard_q      <= discard_d;
      ob_addr_q      <= ob_addr_d;
      count_q        <= count_d;
      fifo_pc_q      <= fifo_pc_d;
      fifo_inst_q    <= fifo_inst_d;
      inst_valid_q   <= inst_valid_d;
      mis_q          <= mis_d;
    end
  end

  assign owImemReqValid = req_valid_q;
  assign owImemAddr     = req_addr_q;
  assign owInstValid    = inst_valid_q;
  assign owInstruction  = fifo_inst_q[0];
  assign owCurrentPc    = fifo_pc_q[0];
  assign owMisalignedPc = mis_q;

endmodule
